// File: rtl/postfix_evaluator.sv
// postfix_evaluator
//   Evaluates a postfix token array on an internal operand stack, one token
//   per clock, and reports a single wrapped two's-complement result plus an
//   error code. Back end of the stack-based ALU.
//
// Ports
//   CLK          rising-edge clock
//   RST          asynchronous, active-high reset
//   start        load request, sampled only while idle
//   postfix      [0][i] = token value, [1][i] = kind flag (bit 0: 1 = operator)
//   token_count  number of valid tokens in slots 0..token_count-1
//   busy         high while a job is in flight, including the done cycle
//   done         one-cycle pulse when result/err_code are updated
//   result       evaluation result, held until the next done
//   err_code     0 ok, 1 underflow, 2 overflow, 3 bad operator,
//                4 unbalanced, 5 bad count
module postfix_evaluator #(
  parameter int N           = 11,
  parameter int W           = 8,
  parameter int STACK_DEPTH = 11
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic [1:0][N-1:0][W-1:0]   postfix,
  input  logic [$clog2(N+1)-1:0]     token_count,
  output logic                       busy,
  output logic                       done,
  output logic [W-1:0]               result,
  output logic [2:0]                 err_code
);

  localparam int CW = $clog2(N+1);
  localparam int SW = $clog2(STACK_DEPTH+1);

  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_UNDER = 3'd1;
  localparam logic [2:0] ERR_OVER  = 3'd2;
  localparam logic [2:0] ERR_OP    = 3'd3;
  localparam logic [2:0] ERR_UNBAL = 3'd4;
  localparam logic [2:0] ERR_COUNT = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        sp_q, sp_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2:0]           pend_err_q, pend_err_d;
  logic [N-1:0][W-1:0]  vals_q, vals_d;
  logic [N-1:0]         kinds_q, kinds_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [W-1:0]         result_q, result_d;
  logic [2:0]           err_code_q, err_code_d;

  // Operand stack; contents are don't-care after reset, so no reset term.
  logic [W-1:0]         stack_q [STACK_DEPTH];
  logic                 push_en;
  logic [SW-1:0]        push_addr;
  logic [W-1:0]         push_data;

  // Only bit 0 of each kind word carries information.
  logic [N-1:0]         kind_in;
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_kind
      logic unused_kind_hi;
      assign kind_in[gi]    = postfix[1][gi][0];
      assign unused_kind_hi = ^postfix[1][gi][W-1:1];
    end
  endgenerate

  logic [W-1:0]  tok_val;
  logic          tok_is_op;
  logic [SW-1:0] sp_m1, sp_m2;
  logic [W-1:0]  op_a, op_b;
  logic [W-1:0]  sum_w, diff_w, prod_w;

  assign tok_val   = vals_q[idx_q];
  assign tok_is_op = kinds_q[idx_q];
  assign sp_m1     = sp_q - SW'(1);
  assign sp_m2     = sp_q - SW'(2);
  assign op_a      = stack_q[sp_m2];
  assign op_b      = stack_q[sp_m1];
  assign sum_w     = op_a + op_b;
  assign diff_w    = op_a - op_b;
  // Low W bits of a two's-complement product equal those of the unsigned
  // product, so a W-bit multiply gives the wrapped signed result directly.
  assign prod_w    = op_a * op_b;

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    idx_d      = idx_q;
    count_d    = count_q;
    pend_err_d = pend_err_q;
    vals_d     = vals_q;
    kinds_d    = kinds_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    err_code_d = err_code_q;
    push_en    = 1'b0;
    push_addr  = sp_q;
    push_data  = tok_val;

    case (state_q)
      S_IDLE: begin
        busy_d = start;
        if (start) begin
          vals_d     = postfix[0];
          kinds_d    = kind_in;
          count_d    = token_count;
          idx_d      = '0;
          sp_d       = '0;
          pend_err_d = ERR_OK;
          if (token_count == '0 || token_count > CW'(N)) begin
            pend_err_d = ERR_COUNT;
            state_d    = S_FINISH;
          end else begin
            state_d    = S_RUN;
          end
        end
      end

      S_RUN: begin
        busy_d = 1'b1;
        idx_d  = idx_q + CW'(1);
        if (!tok_is_op) begin
          if (sp_q == SW'(STACK_DEPTH)) begin
            pend_err_d = ERR_OVER;
            state_d    = S_FINISH;
          end else begin
            push_en   = 1'b1;
            push_addr = sp_q;
            push_data = tok_val;
            sp_d      = sp_q + SW'(1);
          end
        end else if (sp_q < SW'(2)) begin
          pend_err_d = ERR_UNDER;
          state_d    = S_FINISH;
        end else begin
          push_addr = sp_m2;
          sp_d      = sp_m1;
          case (tok_val)
            W'(43): begin push_en = 1'b1; push_data = sum_w;  end
            W'(45): begin push_en = 1'b1; push_data = diff_w; end
            W'(42): begin push_en = 1'b1; push_data = prod_w; end
            default: begin
              sp_d       = sp_q;
              pend_err_d = ERR_OP;
              state_d    = S_FINISH;
            end
          endcase
        end
        // Last token consumed cleanly: wrap up on the next edge.
        if (state_d == S_RUN && idx_q == count_q - CW'(1)) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (pend_err_q == ERR_OK && sp_q == SW'(1)) begin
          result_d   = stack_q[0];
          err_code_d = ERR_OK;
        end else begin
          result_d   = '0;
          err_code_d = (pend_err_q != ERR_OK) ? pend_err_q : ERR_UNBAL;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      sp_q       <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      pend_err_q <= ERR_OK;
      vals_q     <= '0;
      kinds_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      err_code_q <= ERR_OK;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      pend_err_q <= pend_err_d;
      vals_q     <= vals_d;
      kinds_q    <= kinds_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      err_code_q <= err_code_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_en) begin
      stack_q[push_addr] <= push_data;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_postfix_evaluator.sv
// tb_postfix_evaluator
//   Drives two evaluators (default stack depth and a depth-2 stack) from the
//   same inputs and checks them every cycle against a queue-based model, plus
//   directed cases with hand-computed expectations.
module tb_postfix_evaluator;

  localparam int N  = 11;
  localparam int W  = 8;
  localparam int CW = $clog2(N+1);

  logic                     CLK;
  logic                     RST;
  logic                     start;
  logic [1:0][N-1:0][W-1:0] postfix;
  logic [CW-1:0]            token_count;
  logic                     busy_a, done_a, busy_b, done_b;
  logic [W-1:0]             result_a, result_b;
  logic [2:0]               err_a, err_b;

  postfix_evaluator #(.N(N), .W(W), .STACK_DEPTH(11)) dut_a (
    .CLK(CLK), .RST(RST), .start(start), .postfix(postfix),
    .token_count(token_count), .busy(busy_a), .done(done_a),
    .result(result_a), .err_code(err_a)
  );

  postfix_evaluator #(.N(N), .W(W), .STACK_DEPTH(2)) dut_b (
    .CLK(CLK), .RST(RST), .start(start), .postfix(postfix),
    .token_count(token_count), .busy(busy_b), .done(done_b),
    .result(result_b), .err_code(err_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int res;
    int err;
    int lat;   // edges after the accepting edge until the done edge
  } outcome_t;

  function automatic outcome_t evaluate(input logic [1:0][N-1:0][W-1:0] pf,
                                        input int k, input int depth);
    outcome_t o;
    bit [W-1:0] st[$];
    bit [W-1:0] a, b, r;
    o.res = 0; o.err = 0; o.lat = 0;
    if (k == 0 || k > N) begin
      o.err = 5; o.lat = 1;
      return o;
    end
    for (int i = 0; i < k; i++) begin
      if (pf[1][i][0] == 1'b0) begin
        if (st.size() == depth) begin o.err = 2; o.lat = i + 2; return o; end
        st.push_back(pf[0][i]);
      end else begin
        if (st.size() < 2) begin o.err = 1; o.lat = i + 2; return o; end
        if (pf[0][i] != 8'd43 && pf[0][i] != 8'd45 && pf[0][i] != 8'd42) begin
          o.err = 3; o.lat = i + 2; return o;
        end
        b = st.pop_back();
        a = st.pop_back();
        if (pf[0][i] == 8'd43)      r = a + b;
        else if (pf[0][i] == 8'd45) r = a - b;
        else                        r = a * b;
        st.push_back(r);
      end
    end
    o.lat = k + 1;
    if (st.size() == 1) o.res = int'(st[0]);
    else                o.err = 4;
    return o;
  endfunction

  bit       m_active [2];
  int       m_cnt    [2];
  outcome_t m_pend   [2];
  bit       m_busy   [2];
  bit       m_done   [2];
  int       m_res    [2];
  int       m_err    [2];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int d = 0; d < 2; d++) begin
        m_active[d] <= 1'b0; m_cnt[d] <= 0; m_busy[d] <= 1'b0;
        m_done[d] <= 1'b0; m_res[d] <= 0; m_err[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_done[d] <= 1'b0;
        if (!m_active[d]) begin
          m_busy[d] <= start;
          if (start) begin
            m_pend[d]   <= evaluate(postfix, int'(token_count), (d == 0) ? 11 : 2);
            m_active[d] <= 1'b1;
            m_cnt[d]    <= 1;
          end
        end else begin
          m_busy[d] <= 1'b1;
          m_cnt[d]  <= m_cnt[d] + 1;
          if (m_cnt[d] == m_pend[d].lat) begin
            m_active[d] <= 1'b0;
            m_done[d]   <= 1'b1;
            m_res[d]    <= m_pend[d].res;
            m_err[d]    <= m_pend[d].err;
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en && !RST) begin
      chk("busy_a",   int'(busy_a),   int'(m_busy[0]));
      chk("done_a",   int'(done_a),   int'(m_done[0]));
      chk("result_a", int'(result_a), m_res[0]);
      chk("err_a",    int'(err_a),    m_err[0]);
      chk("busy_b",   int'(busy_b),   int'(m_busy[1]));
      chk("done_b",   int'(done_b),   int'(m_done[1]));
      chk("result_b", int'(result_b), m_res[1]);
      chk("err_b",    int'(err_b),    m_err[1]);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic set_tok(input int i, input int v, input bit k);
    postfix[0][i] = W'(v);
    postfix[1][i] = {{(W-1){1'b0}}, k};
  endtask

  task automatic run_case(input string nm, input int k, input int exp_res,
                          input int exp_err, input int exp_lat, input int d);
    int  cycles;
    bit  got;
    @(negedge CLK);
    token_count = CW'(k);
    start       = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 40) begin
      @(posedge CLK);
      #1 cycles++;
      if ((d == 0) ? done_a : done_b) got = 1'b1;
    end
    chk({nm, "_latency"}, got ? cycles : -1, exp_lat);
    chk({nm, "_result"}, (d == 0) ? int'(result_a) : int'(result_b), exp_res);
    chk({nm, "_err"},    (d == 0) ? int'(err_a)    : int'(err_b),    exp_err);
    chk({nm, "_model_result"}, m_res[d], exp_res);
    chk({nm, "_model_err"},    m_err[d], exp_err);
    @(negedge CLK);
  endtask

  task automatic load_case1();
    set_tok(0, 5, 0);  set_tok(1, 4, 0);  set_tok(2, 2, 0);
    set_tok(3, 45, 1); set_tok(4, 1, 0);  set_tok(5, 43, 1);
    set_tok(6, 42, 1); set_tok(7, 6, 0);  set_tok(8, 45, 1);
  endtask

  initial begin
    int n;
    int first_done;
    int second_done;
    int busy_after;
    RST = 1'b1; start = 1'b0; postfix = '0; token_count = '0;
    repeat (2) @(negedge CLK);
    chk("reset_busy",   int'(busy_a),   0);
    chk("reset_done",   int'(done_a),   0);
    chk("reset_result", int'(result_a), 0);
    chk("reset_err",    int'(err_a),    0);
    RST    = 1'b0;
    chk_en = 1'b1;

    // 1) mixed expression
    load_case1();
    run_case("expr9", 9, 9, 0, 10, 0);
    // 2) underflow
    set_tok(0, 3, 0); set_tok(1, 43, 1);
    run_case("underflow", 2, 0, 1, 3, 0);
    // 3) overflow on the depth-2 stack
    set_tok(0, 1, 0); set_tok(1, 2, 0); set_tok(2, 3, 0);
    run_case("overflow", 3, 0, 2, 4, 1);
    // 4) wrapping product and difference
    set_tok(0, 100, 0); set_tok(1, 100, 0); set_tok(2, 42, 1);
    run_case("mul_wrap", 3, 'h10, 0, 4, 0);
    set_tok(0, 1, 0); set_tok(1, 2, 0); set_tok(2, 45, 1);
    run_case("sub_wrap", 3, 'hFF, 0, 4, 0);
    // 5) unbalanced, bad counts, bad operator
    set_tok(0, 1, 0); set_tok(1, 2, 0);
    run_case("unbalanced", 2, 0, 4, 3, 0);
    run_case("count_zero", 0, 0, 5, 1, 0);
    run_case("count_big", 12, 0, 5, 1, 0);
    set_tok(0, 1, 0); set_tok(1, 2, 0); set_tok(2, 47, 1);
    run_case("bad_op", 3, 0, 3, 4, 0);
    set_tok(2, 40, 1);
    run_case("paren_op", 3, 0, 3, 4, 0);

    // Result holds across a new start until the next done.
    set_tok(0, 7, 0);
    run_case("single", 1, 7, 0, 2, 0);

    // 6a) start held high: ignored while busy, re-accepted right after done
    set_tok(0, 1, 0); set_tok(1, 2, 0); set_tok(2, 43, 1);
    @(negedge CLK);
    token_count = CW'(3);
    start       = 1'b1;
    @(posedge CLK);
    n = 0; first_done = -1; second_done = -1; busy_after = -1;
    while (second_done < 0 && n < 40) begin
      @(posedge CLK);
      #1 n++;
      if (n == 5) busy_after = int'(busy_a);
      if (done_a) begin
        if (first_done < 0) first_done = n;
        else                second_done = n;
      end
    end
    start = 1'b0;
    chk("b2b_first_done",  first_done,  4);
    chk("b2b_busy_e5",     busy_after,  1);
    chk("b2b_second_done", second_done, 9);
    chk("b2b_result",      int'(result_a), 3);

    // 6b) reset in the middle of a run
    load_case1();
    run_case("expr9_again", 9, 9, 0, 10, 0);
    @(negedge CLK);
    token_count = CW'(9);
    start       = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midrst_busy",   int'(busy_a),   0);
    chk("midrst_done",   int'(done_a),   0);
    chk("midrst_result", int'(result_a), 0);
    chk("midrst_err",    int'(err_a),    0);
    @(negedge CLK);
    RST = 1'b0;

    // Randomized traffic: tokens and start change every cycle.
    for (int it = 0; it < 3000; it++) begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          set_tok(i, int'($urandom_range(0, 255)), 1'b0);
        end else begin
          case ($urandom_range(0, 7))
            0, 1:    set_tok(i, 43, 1'b1);
            2, 3:    set_tok(i, 45, 1'b1);
            4, 5:    set_tok(i, 42, 1'b1);
            6:       set_tok(i, 47, 1'b1);
            default: set_tok(i, int'($urandom_range(0, 255)), 1'b1);
          endcase
        end
      end
      if ($urandom_range(0, 7) == 0) token_count = CW'($urandom_range(0, 15));
      else                           token_count = CW'($urandom_range(1, N));
      start = ($urandom_range(0, 3) == 0);
    end
    @(negedge CLK);
    start = 1'b0;
    repeat (20) @(negedge CLK);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
